// File: rtl/rom_stream_reader.sv
// Streaming read controller for a synchronous 1-cycle ROM: one (addr, len) command
// becomes len consecutive words on a valid/ready stream, fed by a 4-entry prefetch FIFO.
module rom_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  rom_cs,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and data is held stable while valid & !ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;

  logic [ADDR_WIDTH-1:0]  issue_addr;
  logic [LEN_WIDTH-1:0]   issue_left;
  logic [LEN_WIDTH-1:0]   out_left;
  logic                   cap_pending;
  logic [DATA_WIDTH-1:0]  fifo_mem [4];
  logic [1:0]             wr_ptr;
  logic [1:0]             rd_ptr;
  logic [2:0]             fifo_count;
  logic [1:0]             inflight;
  logic [3:0]             credit;
  logic                   accept;
  logic                   issue_now;
  logic                   push;
  logic                   pop;
  logic [ADDR_WIDTH-1:0]  issue_src;
  logic [LEN_WIDTH-1:0]   left_src;

  assign accept    = cmd_valid & cmd_ready;
  assign inflight  = {1'b0, rom_cs} + {1'b0, cap_pending};
  assign credit    = {1'b0, fifo_count} + {2'b00, inflight};
  assign push      = cap_pending;
  assign pop       = out_valid & out_ready;
  assign out_valid = (fifo_count != 3'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid && (out_left == LEN_WIDTH'(1));

  // The first read launches on the accepting edge itself, giving 2-cycle first-word latency.
  assign issue_src = accept ? cmd_addr : issue_addr;
  assign left_src  = accept ? cmd_len : issue_left;
  assign issue_now = (accept && (cmd_len != '0)) ||
                     ((state == S_RUN) && (issue_left != '0) && (credit < 4'd4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A zero-length command still passes through RUN, so done lands one cycle after acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cmd_valid) state_nxt = S_RUN;
      S_RUN: begin
        if ((out_left == '0) || (pop && (out_left == LEN_WIDTH'(1)))) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_cs      <= 1'b0;
      rom_addr    <= '0;
      cap_pending <= 1'b0;
      issue_addr  <= '0;
      issue_left  <= '0;
      out_left    <= '0;
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
      fifo_count  <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      rom_cs      <= issue_now;
      cap_pending <= rom_cs;
      if (issue_now) begin
        rom_addr   <= issue_src;
        issue_addr <= issue_src + ADDR_WIDTH'(1);
        issue_left <= left_src - LEN_WIDTH'(1);
      end
      if (accept) begin
        out_left <= cmd_len;
      end else if (pop) begin
        out_left <= out_left - LEN_WIDTH'(1);
      end
      if (push) begin
        fifo_mem[wr_ptr] <= rom_dout;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
